// File: rtl/exec_stage_if.sv
// Decode-to-execute instruction handshake: decode (master) offers an
// instruction, the execute stage (slave) answers with in_ready.
interface exec_stage_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [AWIDTH-1:0] in_asel;
    logic [AWIDTH-1:0] in_bsel;
    logic [AWIDTH-1:0] in_wsel;
    logic [DWIDTH-1:0] in_imm;
    logic              in_use_imm;

    modport master (
        output in_valid, in_op, in_asel, in_bsel, in_wsel, in_imm, in_use_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_asel, in_bsel, in_wsel, in_imm, in_use_imm,
        output in_ready
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: bypassed operand fetch, single-cycle ALU and a 16-step
// shift-add multiplier, result returned to the regfile write port.
//
// state  | meaning
// S_IDLE | accepting instructions, ALU results written one cycle later
// S_MUL  | iterating shift-add multiply, decode stalled
module exec_stage #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    exec_stage_if.slave       dec,
    output logic [AWIDTH-1:0] asel,
    output logic [AWIDTH-1:0] bsel,
    input  logic [DWIDTH-1:0] adata,
    input  logic [DWIDTH-1:0] bdata,
    output logic [AWIDTH-1:0] wsel,
    output logic              wreg,
    output logic [DWIDTH-1:0] wdata,
    output logic              busy
);
    localparam int CW = $clog2(DWIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWIDTH - 1);

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state;
    logic [DWIDTH-1:0] mcand;
    logic [DWIDTH-1:0] mplier;
    logic [DWIDTH-1:0] acc;
    logic [CW-1:0]     cnt;
    logic [AWIDTH-1:0] mul_dest;

    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] op_b_reg;
    logic [DWIDTH-1:0] op_b;
    logic [DWIDTH-1:0] alu_res;
    logic              alu_writes;
    logic [DWIDTH-1:0] acc_step;
    logic              accept;

    assign dec.in_ready = (state == S_IDLE);
    assign accept       = dec.in_valid && dec.in_ready;
    assign asel         = dec.in_asel;
    assign bsel         = dec.in_bsel;

    // Result written this cycle is not yet in the regfile, so forward it.
    assign op_a     = (wreg && (wsel == dec.in_asel)) ? wdata : adata;
    assign op_b_reg = (wreg && (wsel == dec.in_bsel)) ? wdata : bdata;
    assign op_b     = dec.in_use_imm ? dec.in_imm : op_b_reg;

    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        alu_res    = '0;
        alu_writes = 1'b1;
        case (dec.in_op)
            OP_MOV:  alu_res = op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = op_a << op_b[3:0];
            OP_SHR:  alu_res = op_a >> op_b[3:0];
            default: alu_writes = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            wreg     <= 1'b0;
            wsel     <= '0;
            wdata    <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            mul_dest <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (dec.in_op == OP_MUL)) begin
                        mcand    <= op_a;
                        mplier   <= op_b;
                        acc      <= '0;
                        cnt      <= '0;
                        mul_dest <= dec.in_wsel;
                        wreg     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_MUL;
                    end else if (accept) begin
                        wsel  <= dec.in_wsel;
                        wdata <= alu_res;
                        wreg  <= alu_writes;
                    end else begin
                        wreg <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    wreg   <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        wdata <= acc_step;
                        wsel  <= mul_dest;
                        wreg  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with a small behavioural regfile attached
// to the read selects and the write port.
module tb_exec_stage;
    logic        clk;
    logic        reset_n;
    logic [3:0]  asel;
    logic [3:0]  bsel;
    logic [15:0] adata;
    logic [15:0] bdata;
    logic [3:0]  wsel;
    logic        wreg;
    logic [15:0] wdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    exec_stage_if #(.AWIDTH(4), .DWIDTH(16)) dif ();

    exec_stage #(.AWIDTH(4), .DWIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dec     (dif),
        .asel    (asel),
        .bsel    (bsel),
        .adata   (adata),
        .bdata   (bdata),
        .wsel    (wsel),
        .wreg    (wreg),
        .wdata   (wdata),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile: preload port for the bench, write port driven by the DUT.
    logic [15:0] rf [16];
    logic        ld;
    logic [3:0]  ld_sel;
    logic [15:0] ld_data;

    always @(posedge clk) begin
        if (ld) rf[ld_sel] <= ld_data;
        else if (wreg) rf[wsel] <= wdata;
    end

    assign adata = rf[asel];
    assign bdata = rf[bsel];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] sel, input logic [15:0] data);
        ld      = 1'b1;
        ld_sel  = sel;
        ld_data = data;
        step();
        ld = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] w, input logic [15:0] imm, input logic ui);
        dif.in_valid   = 1'b1;
        dif.in_op      = op;
        dif.in_asel    = a;
        dif.in_bsel    = b;
        dif.in_wsel    = w;
        dif.in_imm     = imm;
        dif.in_use_imm = ui;
    endtask

    task automatic test_reset();
        dif.in_asel = 4'd5;
        dif.in_bsel = 4'd9;
        #3;
        total++; if (dif.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", dif.in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (wreg !== 1'b0) begin bad++; $display("FAIL reset_wreg got=%b want=0", wreg); end
        total++; if (wsel !== 4'd0) begin bad++; $display("FAIL reset_wsel got=%h want=0", wsel); end
        total++; if (wdata !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", wdata); end
        total++; if (asel !== 4'd5 || bsel !== 4'd9) begin bad++; $display("FAIL sel_copy got=%h/%h want=5/9", asel, bsel); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_add_bypass();
        load(4'd1, 16'd3);
        load(4'd2, 16'd4);
        load(4'd3, 16'h1111);
        load(4'd4, 16'h2222);
        drive(4'd1, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
        step();
        drive(4'd1, 4'd3, 4'd1, 4'd4, 16'h0, 1'b0);
        total++; if (wreg !== 1'b1 || wsel !== 4'd3 || wdata !== 16'd7) begin bad++; $display("FAIL add1 got=%b/%h/%h want=1/3/0007", wreg, wsel, wdata); end
        step();
        drive(4'd1, 4'd1, 4'd4, 4'd5, 16'h0, 1'b0);
        total++; if (wreg !== 1'b1 || wsel !== 4'd4 || wdata !== 16'd10) begin bad++; $display("FAIL add_bypass_a got=%b/%h/%h want=1/4/000a", wreg, wsel, wdata); end
        step();
        dif.in_valid = 1'b0;
        total++; if (wreg !== 1'b1 || wsel !== 4'd5 || wdata !== 16'd13) begin bad++; $display("FAIL add_bypass_b got=%b/%h/%h want=1/5/000d", wreg, wsel, wdata); end
        step();
        total++; if (wreg !== 1'b0 || wsel !== 4'd5 || wdata !== 16'd13) begin bad++; $display("FAIL idle_hold got=%b/%h/%h want=0/5/000d", wreg, wsel, wdata); end
    endtask

    task automatic test_sub_imm();
        load(4'd1, 16'd0);
        drive(4'd2, 4'd1, 4'd0, 4'd2, 16'd1, 1'b1);
        step();
        drive(4'd6, 4'd2, 4'd0, 4'd3, 16'd4, 1'b1);
        total++; if (wreg !== 1'b1 || wsel !== 4'd2 || wdata !== 16'hFFFF) begin bad++; $display("FAIL sub_wrap got=%b/%h/%h want=1/2/ffff", wreg, wsel, wdata); end
        step();
        dif.in_valid = 1'b0;
        total++; if (wreg !== 1'b1 || wsel !== 4'd3 || wdata !== 16'hFFF0) begin bad++; $display("FAIL shl_imm got=%b/%h/%h want=1/3/fff0", wreg, wsel, wdata); end
        step();
    endtask

    task automatic test_logic();
        logic [3:0]  ops  [5] = '{4'd3, 4'd4, 4'd5, 4'd7, 4'd0};
        logic [15:0] imms [5] = '{16'h0, 16'h0, 16'h0, 16'd4, 16'h1234};
        logic        uis  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] exps [5] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0F0F, 16'h1234};
        load(4'd6, 16'hF0F0);
        load(4'd7, 16'h0FF0);
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], 4'd6, 4'd7, 4'd8, imms[i], uis[i]);
            step();
            dif.in_valid = 1'b0;
            total++; if (wreg !== 1'b1 || wsel !== 4'd8 || wdata !== exps[i]) begin bad++; $display("FAIL logic_op%0d got=%b/%h/%h want=1/8/%h", ops[i], wreg, wsel, wdata, exps[i]); end
            step();
        end
    endtask

    task automatic test_mul_timing();
        load(4'd1, 16'd7);
        load(4'd2, 16'd6);
        drive(4'd8, 4'd1, 4'd2, 4'd5, 16'h0, 1'b0);
        step();
        drive(4'd1, 4'd1, 4'd1, 4'd9, 16'h0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            total++; if (dif.in_ready !== 1'b0 || busy !== 1'b1 || wreg !== 1'b0) begin bad++; $display("FAIL mul_stall_c%0d got=rdy%b busy%b wreg%b want=rdy0 busy1 wreg0", i, dif.in_ready, busy, wreg); end
            step();
        end
        total++; if (dif.in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mul_done_ready got=rdy%b busy%b want=rdy1 busy0", dif.in_ready, busy); end
        total++; if (wreg !== 1'b1 || wsel !== 4'd5 || wdata !== 16'd42) begin bad++; $display("FAIL mul_result got=%b/%h/%h want=1/5/002a", wreg, wsel, wdata); end
        step();
        dif.in_valid = 1'b0;
        total++; if (wreg !== 1'b1 || wsel !== 4'd9 || wdata !== 16'd14) begin bad++; $display("FAIL held_instr got=%b/%h/%h want=1/9/000e", wreg, wsel, wdata); end
        step();
    endtask

    task automatic test_mul_overflow_bypass();
        load(4'd1, 16'h0101);
        load(4'd2, 16'h5555);
        load(4'd4, 16'h0001);
        drive(4'd8, 4'd1, 4'd1, 4'd2, 16'h0, 1'b0);
        step();
        drive(4'd1, 4'd2, 4'd4, 4'd3, 16'h0, 1'b0);
        repeat (16) step();
        total++; if (wreg !== 1'b1 || wsel !== 4'd2 || wdata !== 16'h0201) begin bad++; $display("FAIL mul_overflow got=%b/%h/%h want=1/2/0201", wreg, wsel, wdata); end
        step();
        dif.in_valid = 1'b0;
        total++; if (wreg !== 1'b1 || wsel !== 4'd3 || wdata !== 16'h0202) begin bad++; $display("FAIL mul_bypass got=%b/%h/%h want=1/3/0202", wreg, wsel, wdata); end
        step();
    endtask

    task automatic test_nop();
        drive(4'd12, 4'd1, 4'd1, 4'd7, 16'h0, 1'b0);
        step();
        dif.in_valid = 1'b0;
        total++; if (wreg !== 1'b0) begin bad++; $display("FAIL nop_wreg got=%b want=0", wreg); end
        total++; if (dif.in_ready !== 1'b1) begin bad++; $display("FAIL nop_ready got=%b want=1", dif.in_ready); end
        step();
    endtask

    task automatic test_reset_mid_mul();
        load(4'd1, 16'd7);
        load(4'd2, 16'd6);
        drive(4'd8, 4'd1, 4'd2, 4'd5, 16'h0, 1'b0);
        step();
        dif.in_valid = 1'b0;
        repeat (4) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_mul_busy got=%b want=1", busy); end
        reset_n = 1'b0;
        #1;
        total++; if (wreg !== 1'b0 || wdata !== 16'h0 || wsel !== 4'd0) begin bad++; $display("FAIL rst_mid_out got=%b/%h/%h want=0/0/0000", wreg, wsel, wdata); end
        total++; if (dif.in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_state got=rdy%b busy%b want=rdy1 busy0", dif.in_ready, busy); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++; if (wreg !== 1'b0 || dif.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_c%0d got=wreg%b rdy%b want=wreg0 rdy1", i, wreg, dif.in_ready); end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        ld             = 1'b0;
        ld_sel         = 4'd0;
        ld_data        = 16'h0;
        dif.in_valid   = 1'b0;
        dif.in_op      = 4'd0;
        dif.in_asel    = 4'd0;
        dif.in_bsel    = 4'd0;
        dif.in_wsel    = 4'd0;
        dif.in_imm     = 16'h0;
        dif.in_use_imm = 1'b0;
        test_reset();
        test_add_bypass();
        test_sub_imm();
        test_logic();
        test_mul_timing();
        test_mul_overflow_bypass();
        test_nop();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
